// File: rtl/rename_cam_table_pkg.sv
// Shared types and default sizing for the rename CAM map.
// Imported by the interface, the top and the testbench.
package rename_cam_pkg;

  localparam int CELLS_DEF           = 128;
  localparam int VIRT_COUNT_DEF      = 32;
  localparam int WRITE_PORTS_DEF     = 4;
  localparam int READ_PORTS_DEF      = 4;
  localparam int CHECKPOINTS_DEF     = 4;
  localparam int PHYS_ADDR_WIDTH_DEF = $clog2(CELLS_DEF);
  localparam int VIRT_ADDR_WIDTH_DEF = $clog2(VIRT_COUNT_DEF);
  localparam int CKPT_WIDTH_DEF      = $clog2(CHECKPOINTS_DEF);

  typedef logic [PHYS_ADDR_WIDTH_DEF-1:0] phys_addr_t;
  typedef logic [VIRT_ADDR_WIDTH_DEF-1:0] virt_tag_t;
  typedef logic [CKPT_WIDTH_DEF-1:0]      ckpt_id_t;

  typedef struct packed {
    logic      valid;
    virt_tag_t tag;
  } cam_cell_t;

endpackage

// File: rtl/rename_cam_table_if.sv
// Rename/lookup/checkpoint bus of rename_cam_table.
// multi_hit_err exists only when RENAME_CAM_MULTIHIT_CHK_EN is defined.
interface rename_cam_table_if
  import rename_cam_pkg::*;
#(
  parameter int WRITE_PORTS     = WRITE_PORTS_DEF,
  parameter int READ_PORTS      = READ_PORTS_DEF,
  parameter int PHYS_ADDR_WIDTH = PHYS_ADDR_WIDTH_DEF,
  parameter int VIRT_ADDR_WIDTH = VIRT_ADDR_WIDTH_DEF,
  parameter int CKPT_WIDTH      = CKPT_WIDTH_DEF
);

  logic [WRITE_PORTS-1:0]                      wr_en;
  logic [WRITE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0] wr_addr;
  logic [WRITE_PORTS-1:0][VIRT_ADDR_WIDTH-1:0] wr_tag;
  logic [READ_PORTS-1:0]                       rd_en;
  logic [READ_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]  rd_tag;
  logic [READ_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]  rd_addr;
  logic [READ_PORTS-1:0]                       cam_hit;
  logic                                        ckpt_save;
  logic [CKPT_WIDTH-1:0]                       ckpt_id;
  logic                                        ckpt_release;
  logic                                        ckpt_restore;
  logic [CKPT_WIDTH-1:0]                       ckpt_restore_id;
  logic                                        ckpt_full;
  logic                                        ckpt_empty;
`ifdef RENAME_CAM_MULTIHIT_CHK_EN
  logic                                        multi_hit_err;
`endif

  modport master (
    output wr_en, wr_addr, wr_tag, rd_en, rd_tag,
    output ckpt_save, ckpt_release, ckpt_restore, ckpt_restore_id,
    input  rd_addr, cam_hit, ckpt_id, ckpt_full, ckpt_empty
`ifdef RENAME_CAM_MULTIHIT_CHK_EN
    , input multi_hit_err
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_tag, rd_en, rd_tag,
    input  ckpt_save, ckpt_release, ckpt_restore, ckpt_restore_id,
    output rd_addr, cam_hit, ckpt_id, ckpt_full, ckpt_empty
`ifdef RENAME_CAM_MULTIHIT_CHK_EN
    , output multi_hit_err
`endif
  );

endinterface

// File: rtl/rename_cam_table_prio_enc_lsb.sv
// Lowest-set-bit priority encoder: index of the lowest set bit plus a found flag.
module prio_enc_lsb #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan downward so the lowest set bit is the last (winning) assignment.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rename_cam_table.sv
// Multi-port CAM rename map with write-to-read forwarding and a circular
// checkpoint buffer. Optional multi-hit checker: RENAME_CAM_MULTIHIT_CHK_EN.
module rename_cam_table
  import rename_cam_pkg::*;
#(
  parameter int CELLS           = CELLS_DEF,
  parameter int VIRT_COUNT      = VIRT_COUNT_DEF,
  parameter int WRITE_PORTS     = WRITE_PORTS_DEF,
  parameter int READ_PORTS      = READ_PORTS_DEF,
  parameter int CHECKPOINTS     = CHECKPOINTS_DEF,
  parameter int PHYS_ADDR_WIDTH = $clog2(CELLS),
  parameter int VIRT_ADDR_WIDTH = $clog2(VIRT_COUNT),
  parameter int CKPT_WIDTH      = $clog2(CHECKPOINTS)
) (
  input logic               clk,
  input logic               sync_rst,
  input logic               clk_en,
  rename_cam_table_if.slave bus
);

  localparam int CNT_WIDTH = CKPT_WIDTH + 1;

  typedef logic [PHYS_ADDR_WIDTH-1:0] addr_t;
  typedef logic [VIRT_ADDR_WIDTH-1:0] tag_t;
  typedef logic [CKPT_WIDTH-1:0]      cid_t;

  logic [CELLS-1:0]     valid_q, valid_d, valid_w;
  tag_t                 tag_q [CELLS];
  tag_t                 tag_d [CELLS];
  logic [CELLS-1:0]     snap_q [CHECKPOINTS];
  cid_t                 head_q, head_d, tail_q, tail_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [READ_PORTS-1:0][PHYS_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [READ_PORTS-1:0]                      cam_hit_q, cam_hit_d;
  logic [READ_PORTS-1:0][CELLS-1:0]           match_vec;
  logic [READ_PORTS-1:0][PHYS_ADDR_WIDTH-1:0] enc_idx;
  logic [READ_PORTS-1:0]                      enc_found;

  cid_t                   restore_off;
  logic                   restore_ok, save_ok, rel_ok;
  logic [WRITE_PORTS-1:0] wr_act;

  // A restore id is live when its distance from head is below the count.
  always_comb begin
    restore_off = bus.ckpt_restore_id - head_q;
    restore_ok  = bus.ckpt_restore && (CNT_WIDTH'(restore_off) < count_q);
    rel_ok      = bus.ckpt_release && (count_q != '0);
    save_ok     = bus.ckpt_save && (count_q != CNT_WIDTH'(CHECKPOINTS)) && !restore_ok;
    wr_act      = restore_ok ? '0 : bus.wr_en;
  end

  always_comb begin
    head_d  = head_q + cid_t'(rel_ok);
    tail_d  = tail_q + cid_t'(save_ok);
    count_d = count_q + CNT_WIDTH'(save_ok) - CNT_WIDTH'(rel_ok);
    if (restore_ok) begin
      if (rel_ok && (restore_off == '0)) begin
        tail_d  = head_d;
        count_d = '0;
      end else begin
        tail_d  = bus.ckpt_restore_id;
        count_d = CNT_WIDTH'(restore_off) - CNT_WIDTH'(rel_ok);
      end
    end
  end

  // NOTE: always_comb uses blocking '=' so each port sees the cells as already
  // updated by lower (older) ports; sequential state uses '<=' only.
  always_comb begin
    valid_w = valid_q;
    tag_d   = tag_q;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      if (wr_act[i]) begin
        for (int c = 0; c < CELLS; c++) begin
          if (bus.wr_addr[i] == addr_t'(c)) begin
            valid_w[c] = 1'b1;
            tag_d[c]   = bus.wr_tag[i];
          end else if (tag_d[c] == bus.wr_tag[i]) begin
            valid_w[c] = 1'b0;
          end
        end
      end
    end
    valid_d = restore_ok ? snap_q[bus.ckpt_restore_id] : valid_w;
  end

  always_comb begin
    for (int j = 0; j < READ_PORTS; j++) begin
      for (int c = 0; c < CELLS; c++) begin
        match_vec[j][c] = valid_w[c] && (tag_d[c] == bus.rd_tag[j]);
      end
    end
  end

  for (genvar j = 0; j < READ_PORTS; j++) begin : g_enc
    prio_enc_lsb #(.WIDTH(CELLS), .IDX_W(PHYS_ADDR_WIDTH)) u_enc (
      .vec   (match_vec[j]),
      .idx   (enc_idx[j]),
      .found (enc_found[j])
    );
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    logic fwd;
    rd_addr_d = '0;
    cam_hit_d = '0;
    for (int j = 0; j < READ_PORTS; j++) begin
      fwd = 1'b0;
      if (bus.rd_en[j]) begin
        for (int i = 0; i < WRITE_PORTS; i++) begin
          if (wr_act[i] && (bus.wr_tag[i] == bus.rd_tag[j])) begin
            rd_addr_d[j] = bus.wr_addr[i];
            fwd          = 1'b1;
          end
        end
        if (fwd) begin
          cam_hit_d[j] = 1'b1;
        end else if (enc_found[j]) begin
          rd_addr_d[j] = enc_idx[j];
          cam_hit_d[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      valid_q   <= '0;
      for (int c = 0; c < CELLS; c++) tag_q[c] <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rd_addr_q <= '0;
      cam_hit_q <= '0;
    end else if (clk_en) begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      cam_hit_q <= cam_hit_d;
    end
  end

  // NOTE: snapshot storage is not reset; head/tail/count decide which slots
  // are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (!sync_rst && clk_en && save_ok) snap_q[tail_q] <= valid_w;
  end

  assign bus.rd_addr    = rd_addr_q;
  assign bus.cam_hit    = cam_hit_q;
  assign bus.ckpt_id    = tail_q;
  assign bus.ckpt_full  = (count_q == CNT_WIDTH'(CHECKPOINTS));
  assign bus.ckpt_empty = (count_q == '0);

`ifdef RENAME_CAM_MULTIHIT_CHK_EN
  logic multi_hit_q, multi_hit_d, multi_any;

  always_comb begin
    multi_any = 1'b0;
    for (int j = 0; j < READ_PORTS; j++) begin
      if (bus.rd_en[j] && ((match_vec[j] & (match_vec[j] - CELLS'(1))) != '0)) multi_any = 1'b1;
    end
    multi_hit_d = multi_hit_q | multi_any;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      multi_hit_q <= 1'b0;
    end else if (clk_en) begin
      multi_hit_q <= multi_hit_d;
      assert (!multi_any) else $error("rename_cam_table: lookup matched multiple valid cells");
    end
  end

  assign bus.multi_hit_err = multi_hit_q;
`endif

endmodule

// File: doc/rename_cam_table.md
Name: rename_cam_table

Overview:
- Multi-port CAM rename map: one cell per physical register; each cell holds {valid, architectural tag}.
- Lookups search by architectural tag and return the physical index of the live mapping. Results are registered, one-cycle latency.
- Successor to the single-mode CAM map. Adds:
  - per-cell valid bits, with a single live mapping per tag
  - same-cycle write-to-read forwarding
  - a circular checkpoint buffer of valid vectors for branch-mispredict recovery
- Sits between decode/rename and dispatch.

Parameters:
- CELLS, 128, physical registers (CAM entries).
- VIRT_COUNT, 32, architectural registers.
- WRITE_PORTS, 4, rename writes per cycle; a higher port index is younger.
- READ_PORTS, 4, tag lookups per cycle.
- CHECKPOINTS, 4, snapshot slots; must be a power of two, ≥ 2.
- PHYS_ADDR_WIDTH, $clog2(CELLS), physical index width.
- VIRT_ADDR_WIDTH, $clog2(VIRT_COUNT), tag width.
- CKPT_WIDTH, $clog2(CHECKPOINTS), checkpoint id width.

Ports:
- clk  in  1  single clock.
- sync_rst  in  1  synchronous reset, active-high.
- clk_en  in  1  global advance; when low, all state and outputs hold.
- wr_en  in  WRITE_PORTS  write strobes.
- wr_addr  in  WRITE_PORTS×PHYS_ADDR_WIDTH  target cell.
- wr_tag  in  WRITE_PORTS×VIRT_ADDR_WIDTH  tag written.
- rd_en  in  READ_PORTS  lookup strobes.
- rd_tag  in  READ_PORTS×VIRT_ADDR_WIDTH  searched tag.
- rd_addr  out  READ_PORTS×PHYS_ADDR_WIDTH  matching index (registered).
- cam_hit  out  READ_PORTS  match found (registered).
- ckpt_save  in  1  allocate a snapshot.
- ckpt_id  out  CKPT_WIDTH  id of the slot the next save uses (tail).
- ckpt_release  in  1  free the oldest snapshot (head).
- ckpt_restore  in  1  roll back to a snapshot.
- ckpt_restore_id  in  CKPT_WIDTH  snapshot to restore.
- ckpt_full  out  1  count == CHECKPOINTS.
- ckpt_empty  out  1  count == 0.

Behaviour:
- Reset (sync_rst high at clk edge):
  - all valid bits 0, tags 0
  - rd_addr 0, cam_hit 0
  - head, tail and count 0, so ckpt_id 0, ckpt_empty 1, ckpt_full 0
  - reset overrides every other input
- Write on port i:
  - sets cell[wr_addr[i]] = {1, wr_tag[i]}
  - clears valid on every other cell holding wr_tag[i] (single live mapping per tag)
- Write conflicts:
  - same wr_addr on two ports: the higher port wins
  - same wr_tag on two ports: only the higher port's cell stays valid
- Lookup, port j, one-cycle latency:
  - search key is rd_tag[j], using pre-write state plus same-cycle writes
  - if any same-cycle write has wr_tag == rd_tag[j], return the highest such port's wr_addr with hit = 1
  - else return the lowest valid index with a matching tag
  - no match: cam_hit = 0, rd_addr = 0
  - rd_en[j] = 0: cam_hit[j] = 0, rd_addr[j] = 0
- Checkpoint save:
  - when !full, the snapshot at tail takes the post-write valid vector of this cycle, including this cycle's writes
  - tail++ (wraps mod CHECKPOINTS), count++
  - save when full is ignored; no state change
- Checkpoint release:
  - when !empty, head++ (wraps), count--
  - release when empty is ignored
  - save and release in the same cycle: count unchanged, both pointers advance
- Checkpoint restore:
  - the valid vector is loaded from snapshot[ckpt_restore_id]; tags are untouched
  - tail = ckpt_restore_id; count recomputed as (tail − head) mod CHECKPOINTS
  - this frees the restored slot and all younger slots
  - restore has priority: same-cycle writes and save are dropped; release still applies
  - a restore id outside the live window [head, tail) is ignored
  - reads in the restore cycle see pre-restore state
- Reset mid-operation discards all snapshots; there is no partial restore.

Optional Feature:
- Macro: RENAME_CAM_MULTIHIT_CHK_EN.
- Defined:
  - adds sticky output multi_hit_err (1 bit, reset 0)
  - set when any enabled lookup finds ≥ 2 valid cells with the same tag
  - cleared only by sync_rst
  - adds an immediate assertion for simulation
- Undefined: no port, no logic.

Decomposition:
- Package rename_cam_pkg holds:
  - typedef phys_addr_t, virt_tag_t, ckpt_id_t
  - packed struct cam_cell_t {valid, tag}
  - localparam defaults
- One sub-module, prio_enc_lsb: parametrised one-hot/multi-hot vector to the lowest set index plus a found flag. It is used for the lookup hit select.

Test Plan:
- Reset then lookup: rd_en=1, rd_tag=5 → next cycle cam_hit=0, rd_addr=0; ckpt_empty=1, ckpt_id=0.
- Remap clears old mapping: write {addr 10, tag 3}; next cycle write {addr 20, tag 3}; next cycle lookup tag 3 → rd_addr=20, hit=1. Cell 10 is invalid.
- Same-cycle write port conflict: ports 0 and 2 both write tag 7, to addr 30 and addr 31, while port 1 looks up tag 7 → rd_addr=31, hit=1 next cycle.
- Checkpoint and restore:
  - write {40, tag 1}, save (id 0); write {41, tag 1}; lookup tag 1 → 41
  - restore id 0; lookup tag 1 → 40, hit=1
  - ckpt_empty=1, and ckpt_id=0 after restore
- Buffer full and wrap: 4 saves → ckpt_full=1; a 5th save is ignored (ckpt_id stays 0); release then save → ckpt_id wraps to 1, ckpt_full=1.
- Restore beats write: restore id 0 in the same cycle as write {50, tag 9} → lookup tag 9 next-next cycle gives hit=0.
